// File: rtl/lcd_cmd_pkg.sv
// Message codes shared by the game FSM, the LCD arbiter and textlcd,
// plus the arbiter state encoding.
package lcd_cmd_pkg;

   localparam logic [2:0] CMD_CORRECT = 3'b000;
   localparam logic [2:0] CMD_FAIL    = 3'b001;
   localparam logic [2:0] CMD_UP      = 3'b010;
   localparam logic [2:0] CMD_DOWN    = 3'b011;
   localparam logic [2:0] CMD_RETRY   = 3'b100;
   localparam logic [2:0] CMD_START   = 3'b101;
   localparam logic [2:0] CMD_ENTER   = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SHOW = 2'b01,
      S_DFLT = 2'b10
   } state_e;

endpackage

// File: rtl/lcd_msg_arbiter_hold_timer.sv
// Loadable down-counter that measures the message hold window.
// Load has priority over count; the counter parks at zero.
module hold_timer #(
   parameter int CNT_W = 28
) (
   input  logic             clk,
   input  logic             resetn_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn_i || clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Two-source arbiter for the text-LCD command: req0 (game) beats req1 (aux),
// every accepted message is held for HOLD_CYCLES, idle traffic reverts to a prompt.
module lcd_msg_arbiter
   import lcd_cmd_pkg::*;
#(
   parameter int         HOLD_CYCLES = 50_000_000,
   parameter int         IDLE_CYCLES = 250_000_000,
   parameter int         CNT_W       = 28,
   parameter logic [2:0] RESET_CMD   = CMD_START,
   parameter logic [2:0] IDLE_CMD    = CMD_ENTER
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       flush,
   input  logic       req0_valid,
   input  logic [2:0] req0_cmd,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_cmd,
   output logic       req1_ready,
   output logic [2:0] lcd_cmd,
   output logic       lcd_busy,
   output logic       lcd_src
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [2:0]       cmd_q, cmd_d;
   logic             src_q, src_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic             hold_zero;
   logic             acc0, accept;

   // A game message on screen blocks everyone; an aux message only blocks aux.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (resetn && !flush) begin
         case (state_q)
            S_IDLE, S_DFLT: begin
               req0_ready = 1'b1;
               req1_ready = !req0_valid;
            end
            S_SHOW: req0_ready = src_q;
            default: ;
         endcase
      end
   end

   assign acc0   = req0_valid && req0_ready;
   assign accept = acc0 || (req1_valid && req1_ready);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      src_d   = src_q;
      idle_d  = idle_q;
      if (accept) begin
         state_d = S_SHOW;
         cmd_d   = acc0 ? req0_cmd : req1_cmd;
         src_d   = !acc0;
         idle_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (idle_q == IDLE_LAST) begin
                  state_d = S_DFLT;
                  cmd_d   = IDLE_CMD;
                  src_d   = 1'b1;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
            S_SHOW: begin
               if (hold_zero) begin
                  state_d = S_IDLE;
                  idle_d  = '0;
               end
            end
            S_DFLT: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         state_q <= S_IDLE;
         cmd_q   <= RESET_CMD;
         src_q   <= 1'b1;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         src_q   <= src_d;
         idle_q  <= idle_d;
      end
   end

   hold_timer #(
      .CNT_W(CNT_W)
   ) u_hold (
      .clk       (clk),
      .resetn_i  (resetn),
      .clr_i     (flush),
      .load_i    (accept),
      .load_val_i(HOLD_LOAD),
      .en_i      (state_q == S_SHOW),
      .zero_o    (hold_zero)
   );

   assign lcd_cmd  = cmd_q;
   assign lcd_busy = (state_q == S_SHOW);
   assign lcd_src  = src_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed vector table for the documented scenarios, then random traffic
// compared against a timeline-based model of the arbiter.
module tb_lcd_msg_arbiter;

   localparam int H = 4;
   localparam int I = 6;

   logic       clk = 1'b0;
   logic       resetn, flush;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_cmd, req1_cmd;
   logic       req0_ready, req1_ready;
   logic [2:0] lcd_cmd;
   logic       lcd_busy, lcd_src;

   always #5 clk = ~clk;

   lcd_msg_arbiter #(
      .HOLD_CYCLES(H),
      .IDLE_CYCLES(I),
      .CNT_W      (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .req0_valid(req0_valid),
      .req0_cmd  (req0_cmd),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_cmd  (req1_cmd),
      .req1_ready(req1_ready),
      .lcd_cmd   (lcd_cmd),
      .lcd_busy  (lcd_busy),
      .lcd_src   (lcd_src)
   );

   typedef struct {
      logic       rn, fl, v0;
      logic [2:0] c0;
      logic       v1;
      logic [2:0] c1;
      logic       chk;
      logic       e_r0, e_r1;
      logic [2:0] e_cmd;
      logic       e_busy, e_src;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: what is on screen, when the current hold started,
   // and when the current idle period started (cycle numbers).
   int         k = 0;
   int         show_start = -1000;
   int         idle_start = 0;
   bit         dflt = 0;
   bit         known = 0;
   logic [2:0] m_cmd = 3'b101;
   logic       m_src = 1'b1;

   function automatic bit m_busy();
      return known && (k >= show_start) && (k < show_start + H);
   endfunction

   function automatic void add(input logic rn, fl, v0, input logic [2:0] c0,
                               input logic v1, input logic [2:0] c1,
                               input logic r0, r1, input logic [2:0] cmd,
                               input logic busy, src, input int reps = 1);
      vec_t t;
      t.rn = rn; t.fl = fl; t.v0 = v0; t.c0 = c0; t.v1 = v1; t.c1 = c1;
      t.chk = 1'b1; t.e_r0 = r0; t.e_r1 = r1; t.e_cmd = cmd;
      t.e_busy = busy; t.e_src = src;
      for (int r = 0; r < reps; r++) tbl.push_back(t);
   endfunction

   // One clock cycle: drive, compare at negedge, advance model at posedge.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      logic er0, er1, ebusy, esrc, chk;
      logic [2:0] ecmd;
      bit a0, a1;
      resetn = v.rn; flush = v.fl;
      req0_valid = v.v0; req0_cmd = v.c0;
      req1_valid = v.v1; req1_cmd = v.c1;
      @(negedge clk);
      if (!v.rn || v.fl) begin
         er0 = 0; er1 = 0;
      end else if (m_busy()) begin
         er0 = m_src; er1 = 0;
      end else begin
         er0 = 1; er1 = !v.v0;
      end
      ecmd = m_cmd; ebusy = m_busy(); esrc = m_src; chk = known;
      if (use_tbl) begin
         er0 = v.e_r0; er1 = v.e_r1; ecmd = v.e_cmd;
         ebusy = v.e_busy; esrc = v.e_src; chk = v.chk;
      end
      n_checks++;
      if (req0_ready !== er0 || req1_ready !== er1 ||
          (chk && (lcd_cmd !== ecmd || lcd_busy !== ebusy || lcd_src !== esrc)))
         $display("FAIL %s cyc=%0d: rdy0/rdy1/cmd/busy/src got %b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                  tag, k, req0_ready, req1_ready, lcd_cmd, lcd_busy, lcd_src,
                  er0, er1, ecmd, ebusy, esrc);
      else
         n_pass++;
      a0 = v.v0 && er0;
      a1 = v.v1 && er1;
      if (a0 || a1)
         $display("xfer %s cyc=%0d src=%0d cmd=%b", tag, k, a0 ? 0 : 1, a0 ? v.c0 : v.c1);
      @(posedge clk);
      if (!v.rn || v.fl) begin
         m_cmd = 3'b101; m_src = 1; show_start = -1000;
         idle_start = k + 1; dflt = 0; known = 1;
      end else if (a0 || a1) begin
         m_cmd = a0 ? v.c0 : v.c1; m_src = !a0;
         show_start = k + 1; idle_start = k + 1 + H; dflt = 0;
      end else if (known && !m_busy() && !dflt && k == idle_start + I - 1) begin
         dflt = 1; m_cmd = 3'b110; m_src = 1;
      end
      k++;
      #1;
   endtask

   initial begin
      vec_t v;
      resetn = 0; flush = 0; req0_valid = 0; req1_valid = 0;
      req0_cmd = 0; req1_cmd = 0;

      //   rn fl v0 c0      v1 c1      r0 r1 cmd     bsy src reps
      add(0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 0);
      tbl[0].chk = 1'b0;
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 3'b101, 0, 1);
      add(1, 0, 1, 3'b010, 1, 3'b011, 1, 0, 3'b101, 0, 1);
      add(1, 0, 0, 3'b000, 1, 3'b011, 0, 0, 3'b010, 1, 0, 4);
      add(1, 0, 0, 3'b000, 1, 3'b011, 1, 1, 3'b010, 0, 0);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 3'b011, 1, 1, 4);
      add(1, 0, 0, 3'b000, 1, 3'b100, 1, 1, 3'b011, 0, 1);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 3'b100, 1, 1, 2);
      add(1, 0, 1, 3'b000, 0, 3'b000, 1, 0, 3'b100, 1, 1);
      add(1, 0, 0, 3'b000, 1, 3'b001, 0, 0, 3'b000, 1, 0, 4);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 3'b000, 0, 0, 6);
      add(1, 0, 1, 3'b011, 0, 3'b000, 1, 0, 3'b110, 0, 1);
      add(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 3'b011, 1, 0, 4);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 3'b011, 0, 0, 5);
      add(1, 0, 1, 3'b010, 0, 3'b000, 1, 0, 3'b011, 0, 0);
      add(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 3'b010, 1, 0);
      add(1, 1, 1, 3'b001, 0, 3'b000, 0, 0, 3'b010, 1, 0);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 3'b101, 0, 1);
      add(1, 0, 0, 3'b000, 1, 3'b100, 1, 1, 3'b101, 0, 1);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 3'b100, 1, 1);
      add(0, 0, 1, 3'b000, 0, 3'b000, 0, 0, 3'b100, 1, 1);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 3'b101, 0, 1, 6);
      add(1, 0, 0, 3'b000, 1, 3'b010, 1, 1, 3'b110, 0, 1);
      add(1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 3'b010, 1, 1);

      @(posedge clk); #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Random traffic; starts with a reset so the model is in step with the DUT.
      v = tbl[0];
      v.v0 = 0; v.v1 = 0;
      step(v, 1'b0, "rnd_rst");
      for (int i = 0; i < 600; i++) begin
         v.rn = ($urandom_range(0, 99) != 0);
         v.fl = ($urandom_range(0, 59) == 0);
         v.v0 = ($urandom_range(0, 4) == 0);
         v.v1 = ($urandom_range(0, 2) == 0);
         v.c0 = 3'($urandom_range(0, 7));
         v.c1 = 3'($urandom_range(0, 7));
         step(v, 1'b0, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
